// File: rtl/ext_irq_pkg.sv
// Shared types and helpers for the external-interrupt controller.
package ext_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0040;
    localparam int unsigned DEF_VEC_STRIDE = 4;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lowest_set(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ext_irq_ctrl_if.sv
// Flag, mask and request/ack/return signals between the core side and ext_irq_ctrl.
interface ext_irq_ctrl_if #(
    parameter int unsigned NUM_SRC = 2
);
    localparam int unsigned ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] intf;
    logic [NUM_SRC-1:0] irq_mask;
    logic               global_ie;
    logic [NUM_SRC-1:0] pend_clr;
    logic               irq_req;
    logic [ID_W-1:0]    irq_id;
    logic [31:0]        irq_vec;
    logic               irq_ack;
    logic               irq_ret;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output intf, irq_mask, global_ie, pend_clr, irq_ack, irq_ret,
        input  irq_req, irq_id, irq_vec, pending
    );

    modport slave (
        input  intf, irq_mask, global_ie, pend_clr, irq_ack, irq_ret,
        output irq_req, irq_id, irq_vec, pending
    );

endinterface

// File: rtl/irq_toggle_rx.sv
// Toggle-flag receiver: edge detect and sticky pending bits per source.
// Define IRQ_SYNC_EN to insert a 2-flop synchroniser in front of edge detection.
module irq_toggle_rx #(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] i_intf,
    input  logic [NUM_SRC-1:0] i_pend_clr,
    input  logic [NUM_SRC-1:0] i_ack_clr,
    output logic [NUM_SRC-1:0] o_pending
);

    logic [NUM_SRC-1:0] w_intf;
    logic [NUM_SRC-1:0] w_evt;
    logic [NUM_SRC-1:0] w_pending_d;
    logic [NUM_SRC-1:0] r_intf_prev;
    logic [NUM_SRC-1:0] r_pending;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync0;
    logic [NUM_SRC-1:0] r_sync1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= i_intf;
            r_sync1 <= r_sync0;
        end
    end

    assign w_intf = r_sync1;
`else
    assign w_intf = i_intf;
`endif

    assign w_evt = w_intf ^ r_intf_prev;

    // A new event beats any clear arriving in the same cycle.
    assign w_pending_d = w_evt | (r_pending & ~(i_pend_clr | i_ack_clr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_intf_prev <= '0;
            r_pending   <= '0;
        end else begin
            r_intf_prev <= w_intf;
            r_pending   <= w_pending_d;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/ext_irq_ctrl.sv
// External-interrupt controller: pending/mask/priority plus the req/ack/ret
// handshake towards the core's trap logic.
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
    input logic          clk,
    input logic          reset,
    ext_irq_ctrl_if.slave io_bus
);

    localparam int unsigned ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_e             r_state;
    logic               r_irq_req;
    logic [ID_W-1:0]    r_irq_id;
    logic [31:0]        r_irq_vec;

    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [ID_W-1:0]    w_winner;
    logic               w_withdraw;

    irq_toggle_rx #(
        .NUM_SRC (NUM_SRC)
    ) u_toggle_rx (
        .clk        (clk),
        .reset      (reset),
        .i_intf     (io_bus.intf),
        .i_pend_clr (io_bus.pend_clr),
        .i_ack_clr  (w_ack_clr),
        .o_pending  (w_pending)
    );

    assign w_eligible = w_pending & io_bus.irq_mask & {NUM_SRC{io_bus.global_ie}};
    assign w_winner   = ID_W'(lowest_set(32'(w_eligible)));
    assign w_withdraw = !io_bus.irq_mask[r_irq_id] || !io_bus.global_ie ||
                        !w_pending[r_irq_id];

    always_comb begin
        w_ack_clr = '0;
        if (r_state == REQ && io_bus.irq_ack) w_ack_clr[r_irq_id] = 1'b1;
    end

    // Once latched in REQ the id is not re-arbitrated; only withdraw or ack leave REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
            r_irq_vec <= VEC_BASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_eligible) begin
                        r_state   <= REQ;
                        r_irq_req <= 1'b1;
                        r_irq_id  <= w_winner;
                        r_irq_vec <= VEC_BASE + 32'(w_winner) * 32'(VEC_STRIDE);
                    end
                end
                REQ: begin
                    if (io_bus.irq_ack) begin
                        r_state   <= SERVICE;
                        r_irq_req <= 1'b0;
                    end else if (w_withdraw) begin
                        r_state   <= IDLE;
                        r_irq_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (io_bus.irq_ret) r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_irq_req <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.irq_req = r_irq_req;
    assign io_bus.irq_id  = r_irq_id;
    assign io_bus.irq_vec = r_irq_vec;
    assign io_bus.pending = w_pending;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed scenarios plus randomized run vs a model.
module tb_ext_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    ext_irq_ctrl_if #(.NUM_SRC(2)) bus ();

    ext_irq_ctrl #(
        .NUM_SRC    (2),
        .VEC_BASE   (32'h0000_0040),
        .VEC_STRIDE (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: phase 0 = waiting, 1 = requesting, 2 = in handler.
    logic [1:0] m_prev;
    logic [1:0] m_pend;
    int         m_phase;
    int         m_id;
`ifdef IRQ_SYNC_EN
    logic [1:0] m_s0;
    logic [1:0] m_s1;
`endif

    task automatic model_reset();
        m_prev  = 2'b00;
        m_pend  = 2'b00;
        m_phase = 0;
        m_id    = 0;
`ifdef IRQ_SYNC_EN
        m_s0 = 2'b00;
        m_s1 = 2'b00;
`endif
    endtask

    task automatic model_step();
        logic [1:0] seen;
        logic [1:0] evt;
        logic [1:0] elig;
        logic [1:0] np;
        bit         acked;
        if (reset) begin
            model_reset();
            return;
        end
`ifdef IRQ_SYNC_EN
        seen = m_s1;
        m_s1 = m_s0;
        m_s0 = bus.intf;
`else
        seen = bus.intf;
`endif
        evt    = seen ^ m_prev;
        m_prev = seen;
        acked  = (m_phase == 1) && bus.irq_ack;
        for (int i = 0; i < 2; i++) begin
            if (evt[i]) np[i] = 1'b1;
            else if (bus.pend_clr[i] || (acked && m_id == i)) np[i] = 1'b0;
            else np[i] = m_pend[i];
        end
        elig = m_pend & bus.irq_mask & {2{bus.global_ie}};
        case (m_phase)
            0: if (elig != 2'b00) begin
                m_id    = elig[0] ? 0 : 1;
                m_phase = 1;
            end
            1: if (bus.irq_ack) m_phase = 2;
               else if (!bus.irq_mask[m_id] || !bus.global_ie || !m_pend[m_id]) m_phase = 0;
            default: if (bus.irq_ret) m_phase = 0;
        endcase
        m_pend = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.intf      = 2'b00;
        bus.irq_mask  = 2'b00;
        bus.global_ie = 1'b0;
        bus.pend_clr  = 2'b00;
        bus.irq_ack   = 1'b0;
        bus.irq_ret   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL reset_req: got %0h expected 0", bus.irq_req); end
        n_chk++; if (bus.irq_id !== 1'b0) begin n_err++;
            $display("FAIL reset_id: got %0h expected 0", bus.irq_id); end
        n_chk++; if (bus.irq_vec !== 32'h40) begin n_err++;
            $display("FAIL reset_vec: got %0h expected 40", bus.irq_vec); end
        n_chk++; if (bus.pending !== 2'b00) begin n_err++;
            $display("FAIL reset_pending: got %0h expected 0", bus.pending); end
    endtask

    task automatic test_basic();
        bus.irq_mask  = 2'b01;
        bus.global_ie = 1'b1;
        bus.intf      = 2'b01;
        tick();
        repeat (SD) tick();
        n_chk++; if (bus.pending !== 2'b01) begin n_err++;
            $display("FAIL basic_pending: got %0h expected 1", bus.pending); end
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL basic_req_early: got %0h expected 0", bus.irq_req); end
        tick();
        n_chk++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 1'b0 || bus.irq_vec !== 32'h40) begin
            n_err++; $display("FAIL basic_req: got req=%0h id=%0h vec=%0h expected 1/0/40",
                              bus.irq_req, bus.irq_id, bus.irq_vec); end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        n_chk++; if (bus.pending !== 2'b00 || bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL basic_ack: got pend=%0h req=%0h expected 0/0", bus.pending,
                     bus.irq_req); end
        bus.irq_ret = 1'b1; tick(); bus.irq_ret = 1'b0;
        tick();
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL basic_ret: got %0h expected 0", bus.irq_req); end
    endtask

    task automatic test_two_src();
        bus.irq_mask = 2'b11;
        bus.intf     = bus.intf ^ 2'b11;
        tick();
        repeat (SD + 1) tick();
        n_chk++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 1'b0) begin n_err++;
            $display("FAIL two_first: got req=%0h id=%0h expected 1/0", bus.irq_req,
                     bus.irq_id); end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        n_chk++; if (bus.pending !== 2'b10) begin n_err++;
            $display("FAIL two_pending: got %0h expected 2", bus.pending); end
        bus.irq_ret = 1'b1; tick(); bus.irq_ret = 1'b0;
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL two_idle_gap: got %0h expected 0", bus.irq_req); end
        tick();
        n_chk++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 1'b1 || bus.irq_vec !== 32'h44) begin
            n_err++; $display("FAIL two_second: got req=%0h id=%0h vec=%0h expected 1/1/44",
                              bus.irq_req, bus.irq_id, bus.irq_vec); end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.irq_ret = 1'b1; tick(); bus.irq_ret = 1'b0;
    endtask

    task automatic test_mask_withdraw();
        bit got;
        bus.irq_mask = 2'b01;
        bus.intf     = bus.intf ^ 2'b10;
        tick();
        repeat (SD) tick();
        n_chk++; if (bus.pending !== 2'b10) begin n_err++;
            $display("FAIL mask_pending: got %0h expected 2", bus.pending); end
        tick();
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL mask_blocked: got %0h expected 0", bus.irq_req); end
        bus.irq_mask = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            tick();
            got = bus.irq_req;
        end
        n_chk++; if (!got || bus.irq_id !== 1'b1) begin n_err++;
            $display("FAIL mask_unblock: got req=%0h id=%0h expected 1/1", got, bus.irq_id); end
        bus.pend_clr = 2'b10; tick(); bus.pend_clr = 2'b00;
        n_chk++; if (bus.pending !== 2'b00) begin n_err++;
            $display("FAIL withdraw_pending: got %0h expected 0", bus.pending); end
        tick();
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL withdraw_req: got %0h expected 0", bus.irq_req); end
        tick();
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL withdraw_stay: got %0h expected 0", bus.irq_req); end
    endtask

    task automatic test_merge();
        bus.irq_mask = 2'b01;
        bus.intf     = bus.intf ^ 2'b01;
        tick();
        repeat (SD + 1) tick();
        n_chk++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 1'b0) begin n_err++;
            $display("FAIL merge_req: got req=%0h id=%0h expected 1/0", bus.irq_req,
                     bus.irq_id); end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.intf = bus.intf ^ 2'b01; tick();
        bus.intf = bus.intf ^ 2'b01; tick();
        repeat (SD) tick();
        n_chk++; if (bus.pending !== 2'b01 || bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL merge_pending: got pend=%0h req=%0h expected 1/0", bus.pending,
                     bus.irq_req); end
        repeat (3) tick();
        n_chk++; if (bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL merge_no_nest: got %0h expected 0", bus.irq_req); end
        bus.irq_ret = 1'b1; tick(); bus.irq_ret = 1'b0;
        tick();
        n_chk++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 1'b0) begin n_err++;
            $display("FAIL merge_rereq: got req=%0h id=%0h expected 1/0", bus.irq_req,
                     bus.irq_id); end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.irq_ret = 1'b1; tick(); bus.irq_ret = 1'b0;
    endtask

    task automatic test_set_wins();
        bus.irq_mask = 2'b00;
        bus.intf     = bus.intf ^ 2'b01;
        repeat (SD) tick();
        bus.pend_clr = 2'b01; tick(); bus.pend_clr = 2'b00;
        n_chk++; if (bus.pending !== 2'b01) begin n_err++;
            $display("FAIL set_wins: got %0h expected 1", bus.pending); end
        bus.irq_ack = 1'b1; bus.irq_ret = 1'b1; tick();
        bus.irq_ack = 1'b0; bus.irq_ret = 1'b0;
        tick();
        n_chk++; if (bus.pending !== 2'b01 || bus.irq_req !== 1'b0) begin n_err++;
            $display("FAIL spurious_ack: got pend=%0h req=%0h expected 1/0", bus.pending,
                     bus.irq_req); end
        bus.pend_clr = 2'b01; tick(); bus.pend_clr = 2'b00;
    endtask

    task automatic test_reset_mid();
        bus.irq_mask = 2'b10;
        bus.intf     = bus.intf ^ 2'b11;
        tick();
        repeat (SD + 1) tick();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        n_chk++; if (bus.irq_id !== 1'b1 || bus.pending !== 2'b01) begin n_err++;
            $display("FAIL mid_setup: got id=%0h pend=%0h expected 1/1", bus.irq_id,
                     bus.pending); end
        reset = 1'b1;
        #1;
        n_chk++; if (bus.irq_req !== 1'b0 || bus.irq_id !== 1'b0 || bus.irq_vec !== 32'h40 ||
                     bus.pending !== 2'b00) begin n_err++;
            $display("FAIL mid_reset: got req=%0h id=%0h vec=%0h pend=%0h expected 0/0/40/0",
                     bus.irq_req, bus.irq_id, bus.irq_vec, bus.pending); end
        bus.intf = 2'b00;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            bus.intf      = bus.intf ^ {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            bus.irq_mask  = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
            bus.global_ie = ($urandom_range(7) != 0);
            bus.pend_clr  = ($urandom_range(11) == 0) ? 2'($urandom) : 2'b00;
            bus.irq_ack   = bus.irq_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            bus.irq_ret   = ($urandom_range(3) == 0);
            tick();
            n_chk++; if (bus.pending !== m_pend) begin n_err++;
                $display("FAIL rand_pending cyc %0d: got %0h expected %0h", c, bus.pending,
                         m_pend); end
            n_chk++; if (bus.irq_req !== (m_phase == 1)) begin n_err++;
                $display("FAIL rand_req cyc %0d: got %0h expected %0h", c, bus.irq_req,
                         (m_phase == 1)); end
            n_chk++; if (bus.irq_id !== 1'(m_id)) begin n_err++;
                $display("FAIL rand_id cyc %0d: got %0h expected %0h", c, bus.irq_id, m_id); end
            n_chk++; if (bus.irq_vec !== 32'h40 + 32'(m_id) * 4) begin n_err++;
                $display("FAIL rand_vec cyc %0d: got %0h expected %0h", c, bus.irq_vec,
                         32'h40 + 32'(m_id) * 4); end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_two_src();
        test_mask_withdraw();
        test_merge();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
